// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder bit per clk (clk, rst, start, a, b[, sub] -> busy, done, Sum, Carry); SERIAL_ADDER_SUB_EN adds sub for a-b
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef SERIAL_ADDER_SUB_EN
   ,
   input  logic             sub
`endif
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [WIDTH-1:0] ra, rb, ps, psn;
   logic [CW-1:0] cnt;
   logic c, s, cn, last, load, sb;
`ifdef SERIAL_ADDER_SUB_EN
   assign sb = sub;
`else
   assign sb = 1'b0;
`endif
   assign busy = state == RUN;
   assign done = state == DONE;
   always_comb begin
      s = ra[0] ^ rb[0] ^ c;
      cn = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
      psn = (ps >> 1) | (WIDTH'(s) << (WIDTH - 1));
      last = cnt == CW'(WIDTH - 1);
      load = start && state != RUN;
      nxt = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   always_ff @(posedge clk) begin
      if (rst) begin
         ra <= '0;
         rb <= '0;
         ps <= '0;
         c <= 1'b0;
         cnt <= '0;
         Sum <= '0;
         Carry <= 1'b0;
      end else if (load) begin
         ra <= a;
         rb <= b ^ {WIDTH{sb}};
         ps <= '0;
         c <= sb;
         cnt <= '0;
      end else if (state == RUN) begin
         ra <= ra >> 1;
         rb <= rb >> 1;
         ps <= psn;
         c <= cn;
         cnt <= cnt + CW'(1);
         if (last) begin
            Sum <= psn;
            Carry <= cn;
         end
      end
   end
endmodule
